// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: operand register followed by STAGES carry-chain slices.
// Define PIPELINED_ADDSUB_SAT_EN to clamp overflowing results to the signed limits.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned Chunk = WIDTH / STAGES;
   localparam int unsigned Depth = STAGES + 1;

   if (WIDTH < 2 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
   end

   // bx holds b already inverted for subtract; c is the carry into the next slice.
   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] bx;
      logic             c;
      logic [WIDTH-1:0] s;
      logic             ovf;
   } beat_t;

   beat_t st_q [Depth];
   beat_t st_d [Depth];
   logic  advance;

   function automatic beat_t slice_add(input beat_t src, input int unsigned idx);
      beat_t          res;
      logic [Chunk:0] part;
      res  = src;
      part = {1'b0, src.a[idx*Chunk +: Chunk]} + {1'b0, src.bx[idx*Chunk +: Chunk]}
             + {{Chunk{1'b0}}, src.c};
      res.s[idx*Chunk +: Chunk] = part[Chunk-1:0];
      res.c = part[Chunk];
      if (idx == STAGES - 1) begin
         res.ovf = (src.a[WIDTH-1] == src.bx[WIDTH-1]) && (res.s[WIDTH-1] != src.a[WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
         if (res.ovf) begin
            res.s = {src.a[WIDTH-1], {(WIDTH-1){~src.a[WIDTH-1]}}};
         end
`endif
      end
      return res;
   endfunction

   assign advance   = !st_q[Depth-1].vld || out_ready;
   assign in_ready  = advance;
   assign out_valid = st_q[Depth-1].vld;
   assign sum       = st_q[Depth-1].s;
   assign cout      = st_q[Depth-1].c;
   assign ovf       = st_q[Depth-1].ovf;

   always_comb begin
      st_d[0] = st_q[0];
      if (advance) begin
         st_d[0].vld = in_valid;
         st_d[0].a   = a;
         st_d[0].bx  = op ? ~b : b;
         st_d[0].c   = op ? ~cin : cin;
         st_d[0].s   = '0;
         st_d[0].ovf = 1'b0;
      end
      for (int unsigned k = 1; k < Depth; k++) begin
         st_d[k] = advance ? slice_add(st_q[k-1], k - 1) : st_q[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < Depth; k++) begin
         if (rst) begin
            st_q[k] <= '0;
         end else begin
            st_q[k] <= st_d[k];
         end
      end
   end

endmodule
